// File: rtl/key_packer.sv
// key_packer: captures every DECIM-th generator state into a key FIFO and
// serializes each 128-bit key as four 32-bit words, MSW first.
//
// Ports:
//   in_clk       clock, all state updates on rising edge
//   in_rst       synchronous active-high reset
//   in_LFSR      128-bit generator state (sampled on capture)
//   in_wr_seed   seed-write strobe; flushes FIFO, counter and serializer
//   in_stop_req  host request to freeze generation
//   out_stop     generator halt: host request or FIFO full
//   out_word     key word to consumer (0 when not valid)
//   out_valid    out_word valid
//   in_ready     consumer accepts out_word
//   out_last     final (4th) word of a key
//   out_count    keys held in the FIFO, excluding the one being serialized
//
// Serializer states:
//   state  | meaning
//   S_IDLE | no key in flight; pops the FIFO head when one is available
//   S_SEND | presenting word word_idx of key_sr
module key_packer #(
    parameter int DEPTH = 4,
    parameter int DECIM = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic [127:0]             in_LFSR,
    input  logic                     in_wr_seed,
    input  logic                     in_stop_req,
    output logic                     out_stop,
    output logic [31:0]              out_word,
    output logic                     out_valid,
    input  logic                     in_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic {S_IDLE, S_SEND} ser_state_t;

    ser_state_t      state, state_nxt;
    logic [127:0]    fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   dec_cnt;
    logic [127:0]    key_sr;
    logic [1:0]      word_idx;
    logic            advance, capture, pop, xfer;

    // The full condition stalls the generator, so a capture can never find
    // the FIFO full.
    assign out_stop = in_stop_req || (out_count == CNTW'(DEPTH));
    assign advance  = !out_stop && !in_wr_seed;
    assign capture  = advance && (dec_cnt == CW'(DECIM - 1));
    assign xfer     = out_valid && in_ready;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_word  = '0;
        case (state)
            S_IDLE: begin
                if (out_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_word  = key_sr[127:96];
                out_last  = (word_idx == 2'd3);
                if (in_ready && (word_idx == 2'd3)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= S_IDLE;
        end else if (in_wr_seed) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage has no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge in_clk) begin
        if (!in_rst && capture) begin
            fifo_mem[wr_ptr] <= in_LFSR;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst || in_wr_seed) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_count <= '0;
            dec_cnt   <= '0;
            key_sr    <= '0;
            word_idx  <= '0;
        end else begin
            if (advance) begin
                dec_cnt <= (dec_cnt == CW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
            end
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                key_sr   <= fifo_mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
                word_idx <= '0;
            end else if (xfer) begin
                // Shift so the next word is always in the top 32 bits.
                key_sr   <= {key_sr[95:0], 32'h0};
                word_idx <= word_idx + 1'b1;
            end
            case ({capture, pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
        end
    end

endmodule

// File: tb/tb_key_packer.sv
module tb_key_packer;

    localparam int DEPTH = 4;
    localparam int DECIM = 8;
    localparam logic [127:0] SEED = 128'h78947894789478947894789478947894;

    logic                   in_clk = 1'b0;
    logic                   in_rst;
    logic [127:0]           in_LFSR;
    logic                   in_wr_seed;
    logic                   in_stop_req;
    logic                   out_stop;
    logic [31:0]            out_word;
    logic                   out_valid;
    logic                   in_ready;
    logic                   out_last;
    logic [$clog2(DEPTH):0] out_count;

    key_packer #(.DEPTH(DEPTH), .DECIM(DECIM)) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_LFSR     (in_LFSR),
        .in_wr_seed  (in_wr_seed),
        .in_stop_req (in_stop_req),
        .out_stop    (out_stop),
        .out_word    (out_word),
        .out_valid   (out_valid),
        .in_ready    (in_ready),
        .out_last    (out_last),
        .out_count   (out_count)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic gen_rand;
    logic [127:0] gen_val;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // After a seed write the generator value counts advance cycles, so the
    // k-th captured key is k*DECIM + DECIM-1: 7, 15, 23, ...
    task automatic load_expected();
        logic [127:0] key;
        exp_q.delete();
        for (int k = 0; k < 48; k++) begin
            key = 128'(k * DECIM + DECIM - 1);
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back('{word: key[127 - 32*w -: 32], last: (w == 3)});
            end
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #2;
    endtask

    // Generator model: steps when not stopped and not seeding.
    initial begin
        logic adv_s, seed_s;
        gen_val = '0;
        forever begin
            @(negedge in_clk);
            adv_s  = !out_stop && !in_wr_seed;
            seed_s = in_wr_seed;
            @(posedge in_clk);
            #1;
            if (seed_s) gen_val = '0;
            else if (adv_s) gen_val = gen_val + 1;
            in_LFSR = gen_rand ? {$urandom, $urandom, $urandom, $urandom} : gen_val;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic prev_last;
        exp_t e;
        prev_last = 1'b0;
        forever begin
            @(negedge in_clk);
            if (in_rst) begin
                prev_last = 1'b0;
            end else begin
                if (prev_last) check("gap_after_key", out_valid, 1'b0);
                prev_last = 1'b0;
                if (out_valid && in_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected no word", out_word);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", out_word, e.word);
                        check("last", out_last, e.last);
                    end
                    prev_last = out_last;
                end
            end
        end
    end

    // Seed pulse with in_ready low, then measure cycles to first valid.
    task automatic seed_and_check(input string name);
        int n;
        tick();
        in_wr_seed = 1'b1;
        in_LFSR    = SEED;
        in_ready   = 1'b0;
        load_expected();
        tick();
        in_wr_seed = 1'b0;
        in_ready   = 1'b1;
        n = 0;
        while (n < 30) begin
            @(negedge in_clk);
            n++;
            if (n == 1) begin
                check({name, "_valid_after_seed"}, out_valid, 1'b0);
                check({name, "_count_after_seed"}, out_count, 0);
            end
            if (out_valid) break;
        end
        check({name, "_latency"}, n, 10);
    endtask

    task automatic wait_count(input string name, input int target);
        int n;
        n = 0;
        while (out_count != target && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        check({name, "_reached"}, out_count, target);
    endtask

    initial begin
        int   n;
        logic [31:0] held_word;
        logic held_last, stop_all, grew, residual;
        logic [$clog2(DEPTH):0] prev_cnt;

        in_rst = 1'b1; in_wr_seed = 1'b0; in_stop_req = 1'b0; in_ready = 1'b0;
        in_LFSR = '0; gen_rand = 1'b1;

        // Reset
        tick(); tick();
        @(negedge in_clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", out_count, 0);
        check("rst_word",  out_word, 0);
        check("rst_stop",  out_stop, 1'b0);
        check("rst_last",  out_last, 1'b0);
        tick();
        in_stop_req = 1'b1;
        @(negedge in_clk);
        check("rst_stop_follows_req", out_stop, 1'b1);
        tick();
        in_stop_req = 1'b0;
        in_rst = 1'b0;
        gen_rand = 1'b0;

        // Basic flow
        seed_and_check("basic");
        repeat (40) tick();

        // Backpressure
        in_ready = 1'b0;
        n = 0;
        while (!out_stop && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        check("bp_stop", out_stop, 1'b1);
        check("bp_count_full", out_count, DEPTH);
        held_word = out_word;
        held_last = out_last;
        repeat (6) @(negedge in_clk);
        check("bp_word_hold", out_word, held_word);
        check("bp_last_hold", out_last, held_last);
        check("bp_count_hold", out_count, DEPTH);
        check("bp_stop_hold", out_stop, 1'b1);
        tick();
        in_ready = 1'b1;
        n = 0;
        while (out_count == DEPTH && n < 20) begin
            @(negedge in_clk);
            n++;
        end
        check("bp_first_pop_count", out_count, DEPTH - 1);
        check("bp_stop_release", out_stop, 1'b0);
        repeat (60) tick();

        // Seed mid-key
        n = 0;
        while (!(out_valid && in_ready && out_last) && n < 50) begin
            @(negedge in_clk);
            n++;
        end
        tick();
        in_ready = 1'b0;
        wait_count("mid_fill", 2);
        tick();
        in_ready = 1'b1;
        tick();
        tick();
        seed_and_check("mid_seed");

        // Host stop
        repeat (20) tick();
        in_ready = 1'b0;
        wait_count("stop_fill", 2);
        tick();
        in_stop_req = 1'b1;
        in_ready = 1'b1;
        stop_all = 1'b1;
        grew = 1'b0;
        prev_cnt = out_count;
        repeat (20) begin
            @(negedge in_clk);
            if (!out_stop) stop_all = 1'b0;
            if (out_count > prev_cnt) grew = 1'b1;
            prev_cnt = out_count;
        end
        check("stop_held", stop_all, 1'b1);
        check("stop_no_capture", grew, 1'b0);
        check("stop_drained_count", out_count, 0);
        check("stop_drained_valid", out_valid, 1'b0);
        tick();
        in_stop_req = 1'b0;
        repeat (40) tick();

        // Reset mid-word
        in_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge in_clk);
            n++;
        end
        check("rstmid_valid_seen", out_valid, 1'b1);
        tick();
        in_rst = 1'b1;
        exp_q.delete();
        tick();
        in_rst = 1'b0;
        in_ready = 1'b1;
        @(negedge in_clk);
        check("rstmid_valid", out_valid, 1'b0);
        check("rstmid_count", out_count, 0);
        residual = 1'b0;
        repeat (5) begin
            @(negedge in_clk);
            if (out_valid) residual = 1'b1;
        end
        check("rstmid_residual", residual, 1'b0);
        seed_and_check("post_rst");
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
